// File: rtl/fetch_decode_queue.sv
// Byte-stream 6502 instruction assembler and decoder feeding a DEPTH-entry queue
// with a valid/ready handoff to execute; flush discards everything in flight.

package fetch_decode_queue_pkg;
   typedef enum logic [2:0] {
      IMMEDIATE   = 3'd0,
      ZERO_PAGE   = 3'd1,
      ZERO_PAGE_X = 3'd2,
      ABSOLUTE    = 3'd3,
      ABSOLUTE_X  = 3'd4,
      ABSOLUTE_Y  = 3'd5,
      INDIRECT_X  = 3'd6,
      INDIRECT_Y  = 3'd7
   } addressing_mode_t;

   typedef enum logic [2:0] {
      ALU_BYPASS_A = 3'd0,
      ALU_ADC      = 3'd1,
      ALU_SUB      = 3'd2,
      ALU_AND      = 3'd3,
      ALU_OR       = 3'd4,
      ALU_XOR      = 3'd5,
      ALU_CMP      = 3'd6
   } alu_op_t;

   typedef enum logic [1:0] {
      A_REG  = 2'd0,
      X_REG  = 2'd1,
      Y_REG  = 2'd2,
      SP_REG = 2'd3
   } reg_id_t;

   typedef struct packed {
      logic [7:0]       opcode;
      logic [15:0]      operand;
      logic [1:0]       len;
      addressing_mode_t mode;
      alu_op_t          alu_op;
      reg_id_t          src;
      reg_id_t          dst;
      logic             we_rf;
      logic             we_mem;
      logic             illegal;
   } dec_entry_t;
endpackage

// state  | meaning
// S_OPC  | waiting for an opcode byte
// S_LO   | opcode held, waiting for operand low byte
// S_HI   | opcode and low byte held, waiting for operand high byte
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_i,
   output logic             byte_ready_o,
   input  logic             flush_i,
   output logic             dec_valid_o,
   input  logic             dec_ready_i,
   output logic [7:0]       dec_opcode_o,
   output logic [15:0]      dec_operand_o,
   output logic [1:0]       dec_len_o,
   output addressing_mode_t addressing_mode_o,
   output alu_op_t          alu_op_o,
   output reg_id_t          src_reg_addr_o,
   output reg_id_t          dst_reg_addr_o,
   output logic             we_rf_o,
   output logic             we_mem_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_OPC = 2'd0;
   localparam logic [1:0] S_LO  = 2'd1;
   localparam logic [1:0] S_HI  = 2'd2;

   function automatic logic [1:0] f_len(input logic [7:0] op);
      logic [2:0] aaa;
      logic [2:0] bbb;
      aaa = op[7:5];
      bbb = op[4:2];
      f_len = 2'd1;
      case (op[1:0])
         2'b01: f_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
         2'b10: begin
            if (bbb == 3'b011 || bbb == 3'b111)                       f_len = 2'd3;
            else if (bbb == 3'b000 || bbb == 3'b001 || bbb == 3'b101) f_len = 2'd2;
            else                                                      f_len = 2'd1;
         end
         2'b00: begin
            if (op[4:0] == 5'b10000)                  f_len = 2'd2;
            else if (op == 8'h20)                     f_len = 2'd3;
            else if (bbb == 3'b011 || bbb == 3'b111)  f_len = 2'd3;
            else if (bbb == 3'b001 || bbb == 3'b101)  f_len = 2'd2;
            else if (bbb == 3'b000 && aaa >= 3'b101)  f_len = 2'd2;
            else                                      f_len = 2'd1;
         end
         default: f_len = 2'd1;
      endcase
   endfunction

   function automatic dec_entry_t f_decode(input logic [7:0] op, input logic [15:0] operand,
                                           input logic [1:0] len);
      dec_entry_t e;
      e         = '0;
      e.opcode  = op;
      e.operand = operand;
      e.len     = len;
      e.mode    = IMMEDIATE;
      e.alu_op  = ALU_BYPASS_A;
      e.src     = A_REG;
      e.dst     = A_REG;
      e.illegal = (op[1:0] == 2'b11);
      if (op[1:0] == 2'b01) begin
         e.we_rf = 1'b1;
         case (op[4:2])
            3'b000:  e.mode = INDIRECT_X;
            3'b001:  e.mode = ZERO_PAGE;
            3'b010:  e.mode = IMMEDIATE;
            3'b011:  e.mode = ABSOLUTE;
            3'b100:  e.mode = INDIRECT_Y;
            3'b101:  e.mode = ZERO_PAGE_X;
            3'b110:  e.mode = ABSOLUTE_Y;
            default: e.mode = ABSOLUTE_X;
         endcase
         case (op[7:5])
            3'b000:  e.alu_op = ALU_OR;
            3'b001:  e.alu_op = ALU_AND;
            3'b010:  e.alu_op = ALU_XOR;
            3'b011:  e.alu_op = ALU_ADC;
            3'b100: begin
               e.alu_op = ALU_BYPASS_A;
               e.we_rf  = 1'b0;
               e.we_mem = 1'b1;
            end
            3'b101:  e.alu_op = ALU_BYPASS_A;
            3'b110: begin
               e.alu_op = ALU_CMP;
               e.we_rf  = 1'b0;
            end
            default: e.alu_op = ALU_SUB;
         endcase
      end
      return e;
   endfunction

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   logic [1:0]       r_state;
   logic [7:0]       r_opc;
   logic [7:0]       r_lo;
   logic [1:0]       r_len;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   dec_entry_t       r_mem [DEPTH];

   logic             w_accept;
   logic [1:0]       w_byte_len;
   logic             w_push;
   logic             w_pop;
   logic             w_dec_valid;
   logic [7:0]       w_push_opc;
   logic [15:0]      w_push_operand;
   logic [1:0]       w_push_len;
   dec_entry_t       w_head;

   // Ready is withheld while full, so a completing byte always finds a free slot.
   assign byte_ready_o = rstn_i && (r_count < CNT_W'(DEPTH)) && !flush_i;
   assign w_accept     = byte_valid_i && byte_ready_o;
   assign w_byte_len   = f_len(byte_i);
   assign w_dec_valid  = (r_count != '0);
   assign w_pop        = w_dec_valid && dec_ready_i && !flush_i;

   always_comb begin
      w_push         = 1'b0;
      w_push_opc     = r_opc;
      w_push_operand = 16'h0000;
      w_push_len     = r_len;
      case (r_state)
         S_OPC: begin
            if (w_accept && w_byte_len == 2'd1) begin
               w_push     = 1'b1;
               w_push_opc = byte_i;
               w_push_len = 2'd1;
            end
         end
         S_LO: begin
            if (w_accept && r_len == 2'd2) begin
               w_push         = 1'b1;
               w_push_operand = {8'h00, byte_i};
            end
         end
         S_HI: begin
            if (w_accept) begin
               w_push         = 1'b1;
               w_push_operand = {byte_i, r_lo};
            end
         end
         default: w_push = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= S_OPC;
         r_opc    <= 8'h00;
         r_lo     <= 8'h00;
         r_len    <= 2'd0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_state  <= S_OPC;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_accept) begin
            case (r_state)
               S_OPC: begin
                  r_opc <= byte_i;
                  r_len <= w_byte_len;
                  if (w_byte_len != 2'd1) r_state <= S_LO;
               end
               S_LO: begin
                  r_lo    <= byte_i;
                  r_state <= (r_len == 2'd3) ? S_HI : S_OPC;
               end
               default: r_state <= S_OPC;
            endcase
         end
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= f_decode(w_push_opc, w_push_operand, w_push_len);
   end

   assign w_head            = w_dec_valid ? r_mem[r_rd_ptr] : '0;
   assign dec_valid_o       = w_dec_valid;
   assign dec_opcode_o      = w_head.opcode;
   assign dec_operand_o     = w_head.operand;
   assign dec_len_o         = w_head.len;
   assign addressing_mode_o = w_head.mode;
   assign alu_op_o          = w_head.alu_op;
   assign src_reg_addr_o    = w_head.src;
   assign dst_reg_addr_o    = w_head.dst;
   assign we_rf_o           = w_head.we_rf;
   assign we_mem_o          = w_head.we_mem;
   assign illegal_o         = w_head.illegal;
   assign count_o           = r_count;
endmodule
